cfg_regbank_wdt: RTL and testbench

CFG_REGBANK_WDT -- requirements
Module: cfg_regbank_wdt

---
 rtl/cfg_regbank_wdt.sv | 134 +++++++++++++
 tb/tb_cfg_regbank_wdt.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_regbank_wdt.sv
// cfg_regbank_wdt: word-addressed configuration register bank with per-channel
// divider factors and a reloadable watchdog timer with sticky timeout status.
module cfg_regbank_wdt #(
   parameter int          NUM_DIV = 4,
   parameter int          DATA_W  = 32,
   parameter logic [31:0] DIV_RST = 32'hFF,
   parameter int          WDT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req,
   input  logic                      we,
   input  logic [7:0]                addr,
   input  logic [31:0]               wdata,
   output logic                      ack,
   output logic [31:0]               rdata,
   output logic [NUM_DIV*DATA_W-1:0] div_factor,
   output logic [NUM_DIV-1:0]        div_wr_stb,
   output logic                      heartbeat,
   output logic                      timeout
);
   localparam logic [5:0] IDX_CTRL = 6'd0;
   localparam logic [5:0] IDX_STAT = 6'd1;
   localparam logic [5:0] IDX_LOAD = 6'd2;
   localparam logic [5:0] IDX_CNT  = 6'd3;
   localparam logic [5:0] IDX_DIV0 = 6'd4;

   logic [5:0]         word_idx;
   logic               wr;
   logic               ctrl_wr;
   logic               stat_wr;
   logic               load_wr;
   logic [NUM_DIV-1:0] div_hit;
   logic [DATA_W-1:0]  div_q [NUM_DIV];
   logic [WDT_W-1:0]   load_q;
   logic [WDT_W-1:0]   count_q;
   logic [WDT_W-1:0]   count_d;
   logic               en_q;
   logic               en_d;
   logic               timeout_q;
   logic               timeout_d;
   logic               kick;
   logic               en_rise;
   logic               wdt_fire;
   logic               ack_q;
   logic [31:0]        rdata_q;
   logic [31:0]        rd_word;
   logic [NUM_DIV-1:0] stb_q;
   logic               hb_q;
   logic               unused_bits;

   assign word_idx    = addr[7:2];
   assign unused_bits = ^{addr[1:0], wdata};
   assign wr          = req & we;
   assign ctrl_wr     = wr & (word_idx == IDX_CTRL);
   assign stat_wr     = wr & (word_idx == IDX_STAT);
   assign load_wr     = wr & (word_idx == IDX_LOAD);

   for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_div
      assign div_hit[gi] = (word_idx == IDX_DIV0 + 6'(gi));
      assign div_factor[gi*DATA_W +: DATA_W] = div_q[gi];
   end

   always_comb begin
      rd_word = '0;
      case (word_idx)
         IDX_CTRL: rd_word[1]         = en_q;
         IDX_STAT: rd_word[0]         = timeout_q;
         IDX_LOAD: rd_word[WDT_W-1:0] = load_q;
         IDX_CNT:  rd_word[WDT_W-1:0] = count_q;
         default:  ;
      endcase
      for (int i = 0; i < NUM_DIV; i++) begin
         if (div_hit[i]) rd_word[DATA_W-1:0] = div_q[i];
      end
   end

   // Kick and enable-rise both reload; kick beats a coincident expiry, and a
   // timeout set beats a coincident write-one-to-clear.
   always_comb begin
      en_d      = ctrl_wr ? wdata[1] : en_q;
      kick      = ctrl_wr & wdata[0];
      en_rise   = en_d & ~en_q;
      wdt_fire  = 1'b0;
      count_d   = count_q;
      if (kick || en_rise) begin
         count_d = load_q;
      end else if (en_q) begin
         if (load_q == '0) begin
            count_d = '0;
         end else if (count_q == '0) begin
            wdt_fire = 1'b1;
            count_d  = load_q;
         end else begin
            count_d = count_q - WDT_W'(1);
         end
      end
      timeout_d = timeout_q;
      if (stat_wr && wdata[0]) timeout_d = 1'b0;
      if (wdt_fire)            timeout_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         stb_q     <= '0;
         hb_q      <= 1'b0;
         en_q      <= 1'b0;
         count_q   <= '0;
         load_q    <= '0;
         timeout_q <= 1'b0;
         for (int i = 0; i < NUM_DIV; i++) div_q[i] <= DIV_RST[DATA_W-1:0];
      end else begin
         ack_q     <= req;
         rdata_q   <= (req && !we) ? rd_word : '0;
         stb_q     <= div_hit & {NUM_DIV{wr}};
         hb_q      <= kick;
         en_q      <= en_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         if (load_wr) load_q <= wdata[WDT_W-1:0];
         for (int i = 0; i < NUM_DIV; i++) begin
            if (wr && div_hit[i]) div_q[i] <= wdata[DATA_W-1:0];
         end
      end
   end

   assign ack        = ack_q;
   assign rdata      = rdata_q;
   assign div_wr_stb = stb_q;
   assign heartbeat  = hb_q;
   assign timeout    = timeout_q;
endmodule

// File: tb/tb_cfg_regbank_wdt.sv
// Scoreboard bench for cfg_regbank_wdt: directed bus transactions push expected
// responses; a negedge monitor pops and compares on every ack.
module tb_cfg_regbank_wdt;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         req;
   logic         we;
   logic [7:0]   addr;
   logic [31:0]  wdata;
   logic         ack;
   logic [31:0]  rdata;
   logic [127:0] div_factor;
   logic [3:0]   div_wr_stb;
   logic         heartbeat;
   logic         timeout;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic [3:0]  stb;
      logic        hb;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   cfg_regbank_wdt dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .ack        (ack),
      .rdata      (rdata),
      .div_factor (div_factor),
      .div_wr_stb (div_wr_stb),
      .heartbeat  (heartbeat),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Monitor: every ack pops one expectation; idle cycles must be quiet.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn cycle %0d rdata=0x%08h stb=%b hb=%b", cyc, rdata, div_wr_stb, heartbeat);
            chk("ack_latency", cyc, e.due);
            chk("rdata", rdata, e.rdata);
            chk("div_wr_stb", 32'(div_wr_stb), 32'(e.stb));
            chk("heartbeat", 32'(heartbeat), 32'(e.hb));
         end
      end else if (cyc > 0) begin
         chk("idle_rdata", rdata, 32'd0);
         chk("idle_stb", 32'(div_wr_stb), 32'd0);
         chk("idle_hb", 32'(heartbeat), 32'd0);
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("missing_ack", 32'(ack), 32'd1);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic [3:0] es, input bit eh);
      exp_t e;
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      e.due = cyc + 1;
      e.rdata = er;
      e.stb = es;
      e.hb = eh;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req = 1'b0;
      we  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got expired, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      idle(3);
      rst_n = 1'b1;
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_div0", div_factor[31:0], 32'hFF);
      chk("rst_div3", div_factor[127:96], 32'hFF);

      // Divider factors after reset, back-to-back.
      for (int i = 0; i < 4; i++) bus(1'b0, 8'(8'h10 + 4*i), 32'h0, 32'hFF, 4'b0, 1'b0);
      bus(1'b0, 8'h0C, 32'h0, 32'h0, 4'b0, 1'b0);

      // Write then read back-to-back.
      bus(1'b1, 8'h14, 32'h1234, 32'h0, 4'b0010, 1'b0);
      bus(1'b0, 8'h14, 32'h0, 32'h1234, 4'b0, 1'b0);
      chk("div1_value", div_factor[63:32], 32'h1234);
      bus(1'b1, 8'h14, 32'h1234, 32'h0, 4'b0010, 1'b0);
      bus(1'b1, 8'h1F, 32'hCAFE_0001, 32'h0, 4'b1000, 1'b0);
      bus(1'b0, 8'h1C, 32'h0, 32'hCAFE_0001, 4'b0, 1'b0);

      // Unmapped addresses.
      bus(1'b0, 8'h24, 32'h0, 32'h0, 4'b0, 1'b0);
      bus(1'b1, 8'h24, 32'hFFFF, 32'h0, 4'b0, 1'b0);
      bus(1'b0, 8'h40, 32'h0, 32'h0, 4'b0, 1'b0);
      chk("unmapped_div0", div_factor[31:0], 32'hFF);
      chk("unmapped_div2", div_factor[95:64], 32'hFF);

      // Narrow WDT_LOAD field, then load 5.
      bus(1'b1, 8'h08, 32'h0001_2345, 32'h0, 4'b0, 1'b0);
      bus(1'b0, 8'h08, 32'h0, 32'h2345, 4'b0, 1'b0);
      bus(1'b1, 8'h08, 32'h5, 32'h0, 4'b0, 1'b0);
      bus(1'b0, 8'h00, 32'h0, 32'h0, 4'b0, 1'b0);

      // Enable with no kicks: timeout 6 cycles after enable edge E0.
      bus(1'b1, 8'h00, 32'h2, 32'h0, 4'b0, 1'b0);      // E0
      bus(1'b0, 8'h0C, 32'h0, 32'h5, 4'b0, 1'b0);      // E1
      idle(4);                                         // E5
      chk("timeout_before_expiry", 32'(timeout), 32'd0);
      idle(1);                                         // E6
      chk("timeout_at_expiry", 32'(timeout), 32'd1);
      bus(1'b1, 8'h04, 32'h0, 32'h0, 4'b0, 1'b0);      // E7 W1C with 0
      chk("status_w0_keeps", 32'(timeout), 32'd1);
      bus(1'b1, 8'h04, 32'h1, 32'h0, 4'b0, 1'b0);      // E8 clear
      chk("status_w1c", 32'(timeout), 32'd0);
      bus(1'b0, 8'h04, 32'h0, 32'h0, 4'b0, 1'b0);      // E9
      bus(1'b0, 8'h00, 32'h0, 32'h2, 4'b0, 1'b0);      // E10
      idle(1);                                         // E11
      chk("timeout_period_pre", 32'(timeout), 32'd0);
      idle(1);                                         // E12
      chk("timeout_period", 32'(timeout), 32'd1);
      idle(5);                                         // E17
      bus(1'b1, 8'h04, 32'h1, 32'h0, 4'b0, 1'b0);      // E18 clear vs set
      chk("w1c_vs_set", 32'(timeout), 32'd1);

      // Disable freezes counter, timeout retained.
      bus(1'b1, 8'h00, 32'h0, 32'h0, 4'b0, 1'b0);      // E19
      bus(1'b0, 8'h0C, 32'h0, 32'h4, 4'b0, 1'b0);
      idle(5);
      bus(1'b0, 8'h0C, 32'h0, 32'h4, 4'b0, 1'b0);
      chk("frozen_timeout", 32'(timeout), 32'd1);
      bus(1'b1, 8'h04, 32'h1, 32'h0, 4'b0, 1'b0);
      chk("clear_disabled", 32'(timeout), 32'd0);

      // Periodic kicks every 4 cycles keep the watchdog quiet.
      bus(1'b1, 8'h00, 32'h2, 32'h0, 4'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         bus(1'b1, 8'h00, 32'h3, 32'h0, 4'b0, 1'b1);
         idle(3);
         chk("kick_no_timeout", 32'(timeout), 32'd0);
      end
      idle(1);                                         // Kx+4
      bus(1'b0, 8'h0C, 32'h0, 32'h1, 4'b0, 1'b0);      // Kx+5
      bus(1'b1, 8'h00, 32'h3, 32'h0, 4'b0, 1'b1);      // Kx+6 kick at count 0
      chk("kick_at_zero", 32'(timeout), 32'd0);
      bus(1'b0, 8'h0C, 32'h0, 32'h5, 4'b0, 1'b0);      // Kx+7

      // WDT_LOAD=0 suppresses timeouts.
      bus(1'b1, 8'h08, 32'h0, 32'h0, 4'b0, 1'b0);
      idle(8);
      bus(1'b0, 8'h0C, 32'h0, 32'h0, 4'b0, 1'b0);
      chk("load0_no_timeout", 32'(timeout), 32'd0);

      // Reset mid-count during a divider write.
      bus(1'b1, 8'h00, 32'h0, 32'h0, 4'b0, 1'b0);
      bus(1'b1, 8'h08, 32'h5, 32'h0, 4'b0, 1'b0);
      bus(1'b1, 8'h00, 32'h2, 32'h0, 4'b0, 1'b0);      // R0
      idle(3);                                         // R3, count 2
      rst_n = 1'b0; req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 32'hABCD;
      @(posedge clk); #1;
      rst_n = 1'b1; req = 1'b0; we = 1'b0;
      chk("rst_mid_div0", div_factor[31:0], 32'hFF);
      chk("rst_mid_div3", div_factor[127:96], 32'hFF);
      chk("rst_mid_timeout", 32'(timeout), 32'd0);
      bus(1'b0, 8'h0C, 32'h0, 32'h0, 4'b0, 1'b0);
      bus(1'b0, 8'h08, 32'h0, 32'h0, 4'b0, 1'b0);
      bus(1'b0, 8'h00, 32'h0, 32'h0, 4'b0, 1'b0);
      idle(8);
      chk("post_rst_timeout", 32'(timeout), 32'd0);

      idle(3);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
